seg7_hex_display: RTL

- Parametrised N-digit hex driver for the DE2 seven-segment banks; successor to the single-digit hex decoder.
- Captures a packed hex value on a load handshake.
- Decodes the value serially, one digit per cycle, through one shared lookup.
- Holds the decoded patterns in registers and adds per-digit blinking and global blanking.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_digit_lut.sv | 12 +
 rtl/seg7_hex_display.sv | 118 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment hex display: segment patterns, FSM
// state encodings and the digit-index width helper.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}, indexed by hex digit value
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_digit_lut.sv
// Combinational hex-digit to seven-segment lookup, shared by every digit of
// the update walk.
module seg7_digit_lut
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    assign segments = SEG_TABLE[digit];

endmodule

// File: rtl/seg7_hex_display.sv
// N-digit hex driver: captures a packed value, decodes it one digit per cycle
// MSD first, then applies blinking and blanking. Optional SEG7_HEX_DISPLAY_LZB_EN.
module seg7_hex_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int BLINK_DIV  = 25000000
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    iLOAD,
    input  logic [4*NUM_DIGITS-1:0] iVALUE,
    input  logic                    iENABLE,
    input  logic [NUM_DIGITS-1:0]   iBLINK_MASK,
    output logic                    oREADY,
    output logic                    oDONE,
    output logic [7*NUM_DIGITS-1:0] oSEGMENTS
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int CNT_W = (BLINK_DIV <= 2) ? 1 : $clog2(BLINK_DIV);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BLINK_DIV - 1);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] value_q;
    logic [7*NUM_DIGITS-1:0] seg_q;
    logic [CNT_W-1:0]        blink_cnt;
    logic                    blink_phase;

    logic [3:0] cur_digit;
    logic [6:0] cur_pattern;
    logic [6:0] wr_pattern;
    logic       accept;

    assign oREADY = (state == ST_IDLE) || (state == ST_DONE);
    assign oDONE  = (state == ST_DONE);
    assign accept = iLOAD && oREADY;

    assign cur_digit = value_q[4*idx +: 4];

    seg7_digit_lut u_lut (
        .digit    (cur_digit),
        .segments (cur_pattern)
    );

`ifdef SEG7_HEX_DISPLAY_LZB_EN
    logic seen_nz;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            seen_nz <= 1'b0;
        end else if (accept) begin
            seen_nz <= 1'b0;
        end else if (state == ST_UPDATE && cur_digit != 4'd0) begin
            seen_nz <= 1'b1;
        end
    end

    // Digit 0 is never blanked so an all-zero value still shows "0"
    assign wr_pattern = (cur_digit == 4'd0 && !seen_nz && idx != '0) ? SEG_BLANK : cur_pattern;
`else
    assign wr_pattern = cur_pattern;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= ST_IDLE;
            idx     <= '0;
            value_q <= '0;
            seg_q   <= {NUM_DIGITS{SEG_BLANK}};
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (iLOAD) begin
                        value_q <= iVALUE;
                        idx     <= IDX_TOP;
                        state   <= ST_UPDATE;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                ST_UPDATE: begin
                    seg_q[7*idx +: 7] <= wr_pattern;
                    idx               <= idx - 1'b1;
                    if (idx == '0) begin
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_TOP) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Gating is purely combinational so mask/enable changes show up immediately
    always_comb begin
        oSEGMENTS = seg_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!iENABLE || (blink_phase && iBLINK_MASK[k])) begin
                oSEGMENTS[7*k +: 7] = SEG_BLANK;
            end
        end
    end

endmodule
